// File: rtl/pe_mm_sequencer_pkg.sv
// rtl/pe_mm_sequencer_pkg.sv - shared constants and state encoding for the matrix-multiply sequencer
package pe_mm_sequencer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_STREAM = ST_STREAM,
    S_DRAIN  = ST_DRAIN,
    S_WRITE  = ST_WRITE,
    S_DONE   = ST_DONE
  } mm_state_t;

  // Cycles from the PE seeing valid_in with last to output_valid.
  localparam int PE_LATENCY = 3;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/mm_index_counter.sv
// rtl/mm_index_counter.sv - nested i/j/k loop counter with wrap and terminal flags
module mm_index_counter #(
  parameter int DIM_M = 4,
  parameter int DIM_N = 4,
  parameter int DIM_K = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          clr_ij,
  input  logic          clr_k,
  input  logic          inc_k,
  input  logic          inc_ij,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic [CW-1:0] k,
  output logic          i_last,
  output logic          j_last,
  output logic          k_last
);

  assign i_last = (i == CW'(DIM_M - 1));
  assign j_last = (j == CW'(DIM_N - 1));
  assign k_last = (k == CW'(DIM_K - 1));

  // Output-element position: zeroed at job start, stepped once per written element, j innermost.
  always_ff @(posedge clk) begin
    if (clr || clr_ij) begin
      i <= '0;
      j <= '0;
    end else if (inc_ij) begin
      if (j_last) begin
        j <= '0;
        i <= i_last ? '0 : i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

  // Dot-product index: zeroed on START, stepped per issued operand pair.
  always_ff @(posedge clk) begin
    if (clr || clr_k) begin
      k <= '0;
    end else if (inc_k) begin
      k <= k_last ? '0 : k + 1'b1;
    end
  end

endmodule

// File: rtl/pe_mm_sequencer.sv
// rtl/pe_mm_sequencer.sv - operand sequencer and result collector for a single FP MAC PE
module pe_mm_sequencer
  import pe_mm_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_M      = 4,
  parameter int DIM_N      = 4,
  parameter int DIM_K      = 4,
  parameter int ADDR_W     = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W-1:0]     a_rd_addr,
  input  logic [DATA_WIDTH-1:0] a_rd_data,
  output logic [ADDR_W-1:0]     b_rd_addr,
  input  logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  c_wr_en,
  output logic [ADDR_W-1:0]     c_wr_addr,
  output logic [DATA_WIDTH-1:0] c_wr_data,
  output logic                  pe_start,
  output logic                  pe_valid_in,
  output logic                  pe_last,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  input  logic [DATA_WIDTH-1:0] pe_c,
  input  logic                  pe_output_valid
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  mm_state_t         state;
  logic [TW-1:0]     drain_cnt;
  logic [ADDR_W-1:0] i, j, k;
  logic              i_last, j_last, k_last;
  logic              go_accept, issue, write_step;

  assign go_accept  = (state == S_IDLE) && go;
  assign issue      = (state == S_STREAM);
  assign write_step = (state == S_WRITE);

  mm_index_counter #(
    .DIM_M (DIM_M),
    .DIM_N (DIM_N),
    .DIM_K (DIM_K),
    .CW    (ADDR_W)
  ) u_idx (
    .clk    (clk),
    .clr    (clr),
    .clr_ij (go_accept),
    .clr_k  (state == S_START),
    .inc_k  (issue),
    .inc_ij (write_step),
    .i      (i),
    .j      (j),
    .k      (k),
    .i_last (i_last),
    .j_last (j_last),
    .k_last (k_last)
  );

  // Addresses come straight from the counters so RAM data lands one cycle later,
  // the same cycle the delayed issue strobe presents pe_valid_in.
  assign a_rd_addr = ADDR_W'(i * DIM_K + k);
  assign b_rd_addr = ADDR_W'(k * DIM_N + j);

  assign pe_a = a_rd_data;
  assign pe_b = b_rd_data;

  // Job FSM; every control output is a one-cycle-delayed decode of the state it belongs to.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      c_wr_en     <= 1'b0;
      c_wr_addr   <= '0;
      c_wr_data   <= '0;
      pe_start    <= 1'b0;
      pe_valid_in <= 1'b0;
      pe_last     <= 1'b0;
    end else begin
      busy        <= (state inside {S_START, S_STREAM, S_DRAIN, S_WRITE});
      done        <= (state == S_DONE);
      pe_start    <= (state == S_START);
      pe_valid_in <= issue;
      pe_last     <= issue && k_last;
      c_wr_en     <= write_step;
      if (write_step) begin
        c_wr_addr <= ADDR_W'(i * DIM_N + j);
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            err   <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          state <= S_STREAM;
        end
        S_STREAM: begin
          if (k_last) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pe_output_valid) begin
            c_wr_data <= pe_c;
            state     <= S_WRITE;
          end else if (drain_cnt == TW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          state <= (i_last && j_last) ? S_DONE : S_START;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mm_sequencer.sv
// tb/tb_pe_mm_sequencer.sv - directed self-checking bench for pe_mm_sequencer
module tb_pe_mm_sequencer;
  import pe_mm_sequencer_pkg::*;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  // Instance 0: 2x2x2 job, TIMEOUT 8
  logic        go0, busy0, done0, err0, c_wr_en0, pe_start0, pe_valid_in0, pe_last0, pe_ov0;
  logic [7:0]  a_rd_addr0, b_rd_addr0, c_wr_addr0;
  logic [31:0] a_rd_data0, b_rd_data0, c_wr_data0, pe_a0, pe_b0, pe_c0;
  // Instance 1: 2x2x1 job
  logic        go1, busy1, done1, err1, c_wr_en1, pe_start1, pe_valid_in1, pe_last1, pe_ov1;
  logic [7:0]  a_rd_addr1, b_rd_addr1, c_wr_addr1;
  logic [31:0] a_rd_data1, b_rd_data1, c_wr_data1, pe_a1, pe_b1, pe_c1;

  logic [31:0] a_mem0 [0:15];
  logic [31:0] b_mem0 [0:15];
  logic [31:0] c_mem0 [0:15];
  logic [31:0] a_mem1 [0:15];
  logic [31:0] b_mem1 [0:15];
  logic [31:0] c_mem1 [0:15];
  logic [31:0] exp_c  [0:3];
  logic        mem_clear0, mem_clear1, mute0, spur0;
  int          wr_count0, wr_count1;

  pe_mm_sequencer #(.DATA_WIDTH(32), .DIM_M(2), .DIM_N(2), .DIM_K(2), .ADDR_W(8), .TIMEOUT(8)) u_dut0 (
    .clk(clk), .clr(clr), .go(go0), .busy(busy0), .done(done0), .err(err0),
    .a_rd_addr(a_rd_addr0), .a_rd_data(a_rd_data0), .b_rd_addr(b_rd_addr0), .b_rd_data(b_rd_data0),
    .c_wr_en(c_wr_en0), .c_wr_addr(c_wr_addr0), .c_wr_data(c_wr_data0),
    .pe_start(pe_start0), .pe_valid_in(pe_valid_in0), .pe_last(pe_last0),
    .pe_a(pe_a0), .pe_b(pe_b0), .pe_c(pe_c0), .pe_output_valid(pe_ov0)
  );

  pe_mm_sequencer #(.DATA_WIDTH(32), .DIM_M(2), .DIM_N(2), .DIM_K(1), .ADDR_W(8), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .clr(clr), .go(go1), .busy(busy1), .done(done1), .err(err1),
    .a_rd_addr(a_rd_addr1), .a_rd_data(a_rd_data1), .b_rd_addr(b_rd_addr1), .b_rd_data(b_rd_data1),
    .c_wr_en(c_wr_en1), .c_wr_addr(c_wr_addr1), .c_wr_data(c_wr_data1),
    .pe_start(pe_start1), .pe_valid_in(pe_valid_in1), .pe_last(pe_last1),
    .pe_a(pe_a1), .pe_b(pe_b1), .pe_c(pe_c1), .pe_output_valid(pe_ov1)
  );

  always #5 clk = ~clk;

  // Small positive integer-valued floats only.
  function automatic int fp_to_int(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    if (e < 0 || e > 23) return 0;
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] int_to_fp(input int v);
    int p;
    logic [31:0] sh;
    if (v <= 0) return FP_ZERO;
    p = 0;
    for (int b = 0; b < 24; b++) if (v[b]) p = b;
    sh = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), sh[22:0]};
  endfunction

  // Synchronous RAMs and C capture
  always @(posedge clk) begin
    a_rd_data0 <= a_mem0[a_rd_addr0[3:0]];
    b_rd_data0 <= b_mem0[b_rd_addr0[3:0]];
    a_rd_data1 <= a_mem1[a_rd_addr1[3:0]];
    b_rd_data1 <= b_mem1[b_rd_addr1[3:0]];
    if (mem_clear0) begin
      for (int x = 0; x < 16; x++) c_mem0[x] <= 32'hDEAD_BEEF;
    end else if (c_wr_en0) begin
      c_mem0[c_wr_addr0[3:0]] <= c_wr_data0;
      wr_count0 <= wr_count0 + 1;
    end
    if (mem_clear1) begin
      for (int x = 0; x < 16; x++) c_mem1[x] <= 32'hDEAD_BEEF;
    end else if (c_wr_en1) begin
      c_mem1[c_wr_addr1[3:0]] <= c_wr_data1;
      wr_count1 <= wr_count1 + 1;
    end
  end

  // PE models: accumulate, output_valid PE_LATENCY cycles after the last operand
  int acc0, acc1;
  logic [PE_LATENCY-1:0] vq0, vq1;
  logic [31:0] res0, res1;
  always @(posedge clk) begin
    if (clr) begin
      acc0 <= 0; vq0 <= '0; res0 <= '0;
      acc1 <= 0; vq1 <= '0; res1 <= '0;
    end else begin
      if (pe_start0) acc0 <= 0;
      else if (pe_valid_in0) acc0 <= acc0 + fp_to_int(pe_a0) * fp_to_int(pe_b0);
      if (pe_valid_in0 && pe_last0) res0 <= int_to_fp(acc0 + fp_to_int(pe_a0) * fp_to_int(pe_b0));
      vq0 <= {vq0[PE_LATENCY-2:0], pe_valid_in0 && pe_last0 && !mute0};
      if (pe_start1) acc1 <= 0;
      else if (pe_valid_in1) acc1 <= acc1 + fp_to_int(pe_a1) * fp_to_int(pe_b1);
      if (pe_valid_in1 && pe_last1) res1 <= int_to_fp(acc1 + fp_to_int(pe_a1) * fp_to_int(pe_b1));
      vq1 <= {vq1[PE_LATENCY-2:0], pe_valid_in1 && pe_last1};
    end
  end
  assign pe_ov0 = vq0[PE_LATENCY-1] | spur0;
  assign pe_c0  = res0;
  assign pe_ov1 = vq1[PE_LATENCY-1];
  assign pe_c1  = res1;

  task automatic clear_c0;
    mem_clear0 = 1'b1;
    @(negedge clk);
    mem_clear0 = 1'b0;
  endtask

  task automatic run_job0(output int done_n, output int busy_n);
    int n;
    busy_n = 0;
    done_n = -1;
    go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    n = 0;
    while (n < 400 && done_n < 0) begin
      if (done0) done_n = n;
      else if (busy0) busy_n++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    go0 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, done0, err0, c_wr_en0, pe_start0, pe_valid_in0, pe_last0} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl0 got=%b exp=0", {busy0, done0, err0, c_wr_en0, pe_start0, pe_valid_in0, pe_last0});
    end
    checks++;
    if ({a_rd_addr0, b_rd_addr0, c_wr_addr0, c_wr_data0} !== 56'd0) begin
      failures++;
      $display("FAIL reset_data0 got=%h exp=0", {a_rd_addr0, b_rd_addr0, c_wr_addr0, c_wr_data0});
    end
    checks++;
    if ({busy1, done1, err1, c_wr_en1, pe_start1, pe_valid_in1, pe_last1, a_rd_addr1, b_rd_addr1, c_wr_addr1, c_wr_data1} !== 63'd0) begin
      failures++;
      $display("FAIL reset_all1 got=%h exp=0", {busy1, done1, err1, c_wr_en1, pe_start1, pe_valid_in1, pe_last1});
    end
    go0 = 1'b0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_go_ignored got=%b exp=0", busy0);
    end
  endtask

  task automatic test_job_2x2;
    int dn, bn, w0;
    clear_c0();
    w0 = wr_count0;
    run_job0(dn, bn);
    checks++;
    if (dn !== 33) begin failures++; $display("FAIL job_done_cycle got=%0d exp=33", dn); end
    checks++;
    if (bn !== 32) begin failures++; $display("FAIL job_busy_cycles got=%0d exp=32", bn); end
    checks++;
    if (wr_count0 - w0 !== 4) begin failures++; $display("FAIL job_writes got=%0d exp=4", wr_count0 - w0); end
    checks++;
    if (err0 !== 1'b0) begin failures++; $display("FAIL job_err got=%b exp=0", err0); end
    for (int x = 0; x < 4; x++) begin
      checks++;
      if (c_mem0[x] !== exp_c[x]) begin
        failures++;
        $display("FAIL job_c%0d got=%h exp=%h", x, c_mem0[x], exp_c[x]);
      end
    end
  endtask

  task automatic test_framing;
    int n, nvalid, nlast, nstart, bad_last, start_ok, pos;
    logic prev_start;
    logic [7:0] prev_b;
    logic [7:0] bq[$];
    n = 0; nvalid = 0; nlast = 0; nstart = 0; bad_last = 0; start_ok = 0; pos = 0;
    prev_start = 1'b0;
    prev_b = '0;
    go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    while (n < 400 && !done0) begin
      if (pe_start0) nstart++;
      if (pe_valid_in0) begin
        nvalid++;
        pos++;
        if (pos == 1 && prev_start) start_ok++;
        if (pe_last0 !== (pos == 2)) bad_last++;
        if (pe_last0) begin nlast++; pos = 0; end
        bq.push_back(prev_b);
      end
      prev_start = pe_start0;
      prev_b = b_rd_addr0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done0) begin failures++; $display("FAIL frame_done got=%b exp=1", done0); end
    checks++;
    if (nvalid !== 8) begin failures++; $display("FAIL frame_valid_count got=%0d exp=8", nvalid); end
    checks++;
    if (nlast !== 4 || bad_last !== 0) begin failures++; $display("FAIL frame_last got=%0d/%0d exp=4/0", nlast, bad_last); end
    checks++;
    if (nstart !== 4 || start_ok !== 4) begin failures++; $display("FAIL frame_start got=%0d/%0d exp=4/4", nstart, start_ok); end
    checks++;
    if (bq.size() < 4) begin
      failures++;
      $display("FAIL frame_b_addr got=%0d entries exp=8", bq.size());
    end else if (bq[2] !== 8'd1 || bq[3] !== 8'd3) begin
      failures++;
      $display("FAIL frame_b_addr got=%0d,%0d exp=1,3", bq[2], bq[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_k1;
    int n, dn, bad_period, nw, last_w;
    n = 0; dn = -1; bad_period = 0; nw = 0; last_w = 0;
    mem_clear1 = 1'b1;
    @(negedge clk);
    mem_clear1 = 1'b0;
    go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    while (n < 400 && dn < 0) begin
      if (done1) dn = n;
      if (c_wr_en1) begin
        if (n - last_w != 7) bad_period++;
        last_w = n;
        nw++;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (dn !== 29) begin failures++; $display("FAIL k1_done_cycle got=%0d exp=29", dn); end
    checks++;
    if (nw !== 4 || bad_period !== 0) begin failures++; $display("FAIL k1_period got=%0d/%0d exp=4/0", nw, bad_period); end
    for (int x = 0; x < 4; x++) begin
      checks++;
      if (c_mem1[x] !== 32'h4000_0000) begin
        failures++;
        $display("FAIL k1_c%0d got=%h exp=40000000", x, c_mem1[x]);
      end
    end
  endtask

  task automatic test_timeout;
    int dn, bn, w0;
    clear_c0();
    mute0 = 1'b1;
    w0 = wr_count0;
    run_job0(dn, bn);
    checks++;
    if (dn !== 12) begin failures++; $display("FAIL to_done_cycle got=%0d exp=12", dn); end
    checks++;
    if (err0 !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", err0); end
    checks++;
    if (wr_count0 - w0 !== 0) begin failures++; $display("FAIL to_writes got=%0d exp=0", wr_count0 - w0); end
    mute0 = 1'b0;
    run_job0(dn, bn);
    checks++;
    if (err0 !== 1'b0 || dn !== 33) begin failures++; $display("FAIL to_recover got=%b/%0d exp=0/33", err0, dn); end
    checks++;
    if (c_mem0[3] !== 32'h4248_0000) begin failures++; $display("FAIL to_recover_c3 got=%h exp=42480000", c_mem0[3]); end
  endtask

  task automatic test_clr_mid;
    int n, dn, bn, w0;
    clear_c0();
    w0 = wr_count0;
    go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    n = 0;
    while (n < 17) begin
      @(negedge clk);
      n++;
    end
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy0, done0, err0, c_wr_en0, pe_start0, pe_valid_in0, pe_last0, a_rd_addr0, b_rd_addr0, c_wr_addr0, c_wr_data0} !== 63'd0) begin
      failures++;
      $display("FAIL clr_outputs got=%h exp=0",
               {busy0, done0, err0, c_wr_en0, pe_start0, pe_valid_in0, pe_last0, a_rd_addr0, b_rd_addr0, c_wr_addr0, c_wr_data0});
    end
    clr = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (wr_count0 - w0 !== 2) begin failures++; $display("FAIL clr_writes got=%0d exp=2", wr_count0 - w0); end
    checks++;
    if (c_mem0[2] !== 32'hDEAD_BEEF || c_mem0[3] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL clr_no_write got=%h,%h exp=deadbeef", c_mem0[2], c_mem0[3]);
    end
    run_job0(dn, bn);
    checks++;
    if (dn !== 33) begin failures++; $display("FAIL clr_rerun_done got=%0d exp=33", dn); end
    for (int x = 0; x < 4; x++) begin
      checks++;
      if (c_mem0[x] !== exp_c[x]) begin
        failures++;
        $display("FAIL clr_rerun_c%0d got=%h exp=%h", x, c_mem0[x], exp_c[x]);
      end
    end
  endtask

  task automatic test_go_held;
    int n, dn, w0, w34;
    logic b33, b34, b35;
    clear_c0();
    w0 = wr_count0;
    dn = -1; w34 = -1; b33 = 1'bx; b34 = 1'bx; b35 = 1'bx;
    go0 = 1'b1;
    @(negedge clk);
    n = 0;
    while (n < 40) begin
      spur0 = (n == 1);
      if (done0 && dn < 0) dn = n;
      if (n == 33) b33 = busy0;
      if (n == 34) begin b34 = busy0; w34 = wr_count0 - w0; end
      if (n == 35) b35 = busy0;
      @(negedge clk);
      n++;
    end
    spur0 = 1'b0;
    go0 = 1'b0;
    checks++;
    if (dn !== 33) begin failures++; $display("FAIL held_done_cycle got=%0d exp=33", dn); end
    checks++;
    if (w34 !== 4) begin failures++; $display("FAIL held_writes got=%0d exp=4", w34); end
    checks++;
    if ({b33, b34, b35} !== 3'b001) begin failures++; $display("FAIL held_restart got=%b exp=001", {b33, b34, b35}); end
    n = 0;
    while (n < 100 && !done0) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (wr_count0 - w0 !== 8) begin failures++; $display("FAIL held_second_job got=%0d exp=8", wr_count0 - w0); end
    checks++;
    if (c_mem0[1] !== 32'h41B0_0000) begin failures++; $display("FAIL held_c1 got=%h exp=41b00000", c_mem0[1]); end
  endtask

  initial begin
    clk = 1'b0;
    clr = 1'b1;
    go0 = 1'b0; go1 = 1'b0;
    mute0 = 1'b0; spur0 = 1'b0;
    mem_clear0 = 1'b0; mem_clear1 = 1'b0;
    wr_count0 = 0; wr_count1 = 0;
    checks = 0; failures = 0;
    // A = [[1,2],[3,4]], B = [[5,6],[7,8]] for the 2x2x2 instance
    for (int x = 0; x < 16; x++) begin
      a_mem0[x] = FP_ZERO; b_mem0[x] = FP_ZERO;
      a_mem1[x] = FP_ONE;  b_mem1[x] = 32'h4000_0000;
    end
    a_mem0[0] = 32'h3F80_0000; a_mem0[1] = 32'h4000_0000; a_mem0[2] = 32'h4040_0000; a_mem0[3] = 32'h4080_0000;
    b_mem0[0] = 32'h40A0_0000; b_mem0[1] = 32'h40C0_0000; b_mem0[2] = 32'h40E0_0000; b_mem0[3] = 32'h4100_0000;
    exp_c[0] = 32'h4198_0000; exp_c[1] = 32'h41B0_0000; exp_c[2] = 32'h422C_0000; exp_c[3] = 32'h4248_0000;
    @(negedge clk);
    test_reset();
    test_job_2x2();
    test_framing();
    test_k1();
    test_timeout();
    test_clr_mid();
    test_go_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_mm_sequencer.md
Name: pe_mm_sequencer

Overview:
- Drives the operand side of the single-PE floating-point multiply-accumulate datapath and collects its results.
- For C = A x B (M x K times K x N, IEEE-754 single precision) it reads A and B from synchronous-read RAMs and, for each (i,j), streams K operand pairs into the PE with start/valid/last framing.
- It waits for the PE's output_valid, then writes the result into C RAM.
- Sits between the matrix buffers and the PE; it is the initiator for the PE's stream interface.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- DIM_M, 4, rows of A and C.
- DIM_N, 4, columns of B and C.
- DIM_K, 4, inner dimension, i.e. dot-product length; must be >= 1.
- ADDR_W, 8, RAM address width; must cover DIM_M*DIM_K, DIM_K*DIM_N and DIM_M*DIM_N.
- TIMEOUT, 64, maximum DRAIN cycles before abort.

Ports:
- clk  in  1  clock.
- clr  in  1  synchronous active-high reset.
- go  in  1  start matrix job; sampled only in IDLE.
- busy  out  1  high from the cycle after go is accepted until done.
- done  out  1  one-cycle pulse when the job completes or aborts.
- err  out  1  sticky timeout flag; cleared by the next accepted go or by clr.
- a_rd_addr  out  ADDR_W  A address, row-major i*DIM_K+k.
- a_rd_data  in  DATA_WIDTH  A data, valid 1 cycle after address.
- b_rd_addr  out  ADDR_W  B address, row-major k*DIM_N+j.
- b_rd_data  in  DATA_WIDTH  B data, 1-cycle latency.
- c_wr_en  out  1  C write strobe.
- c_wr_addr  out  ADDR_W  C address, row-major i*DIM_N+j.
- c_wr_data  out  DATA_WIDTH  C write data.
- pe_start  out  1  clears PE accumulator.
- pe_valid_in  out  1  PE operand valid.
- pe_last  out  1  last operand of the dot product.
- pe_a  out  DATA_WIDTH  equals a_rd_data.
- pe_b  out  DATA_WIDTH  equals b_rd_data.
- pe_c  in  DATA_WIDTH  PE accumulated result.
- pe_output_valid  in  1  pe_c holds the final dot product.

Behaviour:
- Reset: clr has priority over everything. It sends the FSM to IDLE and zeroes i, j, k and the timeout counter. All outputs read 0 (busy, done, err, c_wr_en, pe_start, pe_valid_in, pe_last, all addresses, c_wr_data).
- clr mid-job abandons the job with no further C writes. The PE is reset by its own reset, tied to the same source.
- FSM states: IDLE, START, STREAM, DRAIN, WRITE, DONE.
- IDLE: if go=1, clear err, zero i/j, go to START. go in any other state is ignored.
- START: pe_start=1 for exactly one cycle, k=0, go to STREAM.
- STREAM: one cycle per k = 0..DIM_K-1. Drive a_rd_addr=i*DIM_K+k and b_rd_addr=k*DIM_N+j.
  - A one-cycle-delayed copy of the issue strobe drives pe_valid_in, so it is aligned with RAM data.
  - pe_last is the delayed copy of (k==DIM_K-1).
  - After k=DIM_K-1, go to DRAIN.
- DRAIN: count cycles and wait for pe_output_valid.
  - On pe_output_valid: register pe_c into c_wr_data, go to WRITE.
  - If the count reaches TIMEOUT: set err, go to DONE with no write.
  - pe_output_valid seen outside DRAIN is ignored.
- WRITE: c_wr_en=1 with c_wr_addr=i*DIM_N+j for one cycle.
  - Advance j; on wrap (j==DIM_N-1) reset j and advance i.
  - If i==DIM_M-1 and j==DIM_N-1, go to DONE; else go to START.
- DONE: done=1 for one cycle, busy=0 from this cycle, go to IDLE.
- pe_start is never asserted while a previous dot product is in flight. This is guaranteed because START is only entered after WRITE.
- Timing, with the nominal PE latency of 3 cycles from valid_in to output_valid: each C element takes DIM_K+6 cycles. done is asserted DIM_M*DIM_N*(DIM_K+6)+1 cycles after the go-sampling edge.
- Address arithmetic uses constant multiplies of the loop counters, with no carry beyond ADDR_W.
- Data is passed through unmodified; the sequencer does no float arithmetic.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit localparams);
  - the PE pipeline-latency constant (3);
  - IEEE-754 constants used by benches (ONE=0x3F800000, ZERO=0x00000000).
- One natural sub-module: mm_index_counter, the nested i/j/k counter with wrap and terminal flags.

Test Plan:
- M=N=K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], real pe_no_fifo behind an inverted clr, go pulsed -> C RAM = 0x41980000, 0x41B00000, 0x422C0000, 0x42480000 at addrs 0..3; done exactly 33 cycles after go; busy high for the 32 cycles between.
- Same job, probe PE framing -> per element: pe_start one cycle before the first pe_valid_in; exactly 2 pe_valid_in; pe_last only on the 2nd; b_rd_addr sequence for (0,1) is 1,3.
- K=1, A=all 1.0, B=all 2.0 -> every C word = 0x40000000; per-element period 7 cycles.
- PE model that never asserts output_valid, TIMEOUT=8 -> err=1, done pulse, no c_wr_en. A following go clears err and completes normally.
- clr asserted during STREAM of element (1,0) -> all outputs 0 on the next cycle; no further C writes. A fresh go reproduces the correct results from scenario 1.
- go held high throughout a job plus spurious pe_output_valid during STREAM -> only one job runs; no extra writes; done still at cycle 33; the job restarts only after IDLE is re-entered.
